bp_be_multistream_prefetch_gen: RTL and testbench

//   Multi-stream successor to the single-stream BE prefetch generator. Holds up to

---
 rtl/bp_be_multistream_prefetch_gen.sv | 156 +++++++++++++++
 tb/tb_bp_be_multistream_prefetch_gen.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_multistream_prefetch_gen.sv
// Multi-stream strided prefetch generator: up to streams_p concurrent streams,
// round-robin issue of one prefetch vaddr per consumed request.
module bp_be_multistream_prefetch_gen #(
  parameter int streams_p = 4,
  parameter int vaddr_width_p = 39,
  parameter int stride_width_p = 8,
  parameter int count_width_p = 8,
  localparam int lg_streams_lp = $clog2(streams_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      alloc_v_i,
  output logic                      alloc_ready_and_o,
  input  logic [vaddr_width_p-1:0]  alloc_pc_i,
  input  logic [vaddr_width_p-1:0]  alloc_addr_i,
  input  logic [stride_width_p-1:0] alloc_stride_i,
  input  logic [count_width_p-1:0]  alloc_count_i,
  input  logic                      clear_i,
  input  logic                      kill_v_i,
  input  logic [vaddr_width_p-1:0]  kill_pc_i,
  output logic                      pref_v_o,
  output logic [vaddr_width_p-1:0]  pref_addr_o,
  output logic [vaddr_width_p-1:0]  pref_pc_o,
  output logic [lg_streams_lp-1:0]  pref_stream_o,
  input  logic                      pref_yumi_i,
  output logic [streams_p-1:0]      active_o
);

  typedef enum logic {
    e_idle,
    e_active
  } state_e;

  typedef logic [vaddr_width_p-1:0]  vaddr_t;
  typedef logic [stride_width_p-1:0] stride_t;
  typedef logic [count_width_p-1:0]  count_t;
  typedef logic [lg_streams_lp-1:0]  idx_t;

  function automatic vaddr_t sext(input stride_t s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  state_e  state_q [streams_p];
  state_e  state_d [streams_p];
  vaddr_t  pc_q    [streams_p];
  vaddr_t  pc_d    [streams_p];
  vaddr_t  addr_q  [streams_p];
  vaddr_t  addr_d  [streams_p];
  stride_t stride_q[streams_p];
  stride_t stride_d[streams_p];
  count_t  count_q [streams_p];
  count_t  count_d [streams_p];
  idx_t    rr_q, rr_d;

  logic [streams_p-1:0] active;
  logic [streams_p-1:0] hit_v;
  logic [streams_p-1:0] kill_hit;
  idx_t hit_idx, fill_idx, alloc_idx;
  idx_t grant_idx, cand;
  logic hit_any, alloc_drop, alloc_we, yumi;

  always_comb begin
    for (int i = 0; i < streams_p; i++) begin
      active[i]   = (state_q[i] == e_active);
      hit_v[i]    = active[i] && (pc_q[i] == alloc_pc_i);
      kill_hit[i] = kill_v_i && active[i] && (pc_q[i] == kill_pc_i);
    end
  end

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit_idx  = '0;
    fill_idx = '0;
    for (int i = streams_p-1; i >= 0; i--) begin
      if (hit_v[i])   hit_idx  = idx_t'(i);
      if (!active[i]) fill_idx = idx_t'(i);
    end
  end

  assign hit_any = |hit_v;
  assign alloc_ready_and_o = (~&active) | hit_any;
  assign alloc_idx = hit_any ? hit_idx : fill_idx;

  // Zero-work descriptors and ones racing a kill of their own PC are swallowed.
  assign alloc_drop = (alloc_count_i == '0)
                    | (alloc_stride_i == '0)
                    | (kill_v_i && (kill_pc_i == alloc_pc_i));
  assign alloc_we = alloc_v_i & alloc_ready_and_o & ~clear_i & ~alloc_drop;

  always_comb begin
    grant_idx = rr_q;
    cand = '0;
    for (int k = streams_p-1; k >= 0; k--) begin
      cand = rr_q + idx_t'(k);
      if (active[cand]) grant_idx = cand;
    end
  end

  assign pref_v_o      = |active;
  assign pref_addr_o   = addr_q[grant_idx];
  assign pref_pc_o     = pc_q[grant_idx];
  assign pref_stream_o = grant_idx;
  assign active_o      = active;
  assign yumi          = pref_yumi_i & pref_v_o;

  // Later assignments override earlier ones: yumi < alloc < kill < clear.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    count_d  = count_q;
    rr_d     = rr_q;
    if (yumi) begin
      addr_d[grant_idx]  = addr_q[grant_idx] + sext(stride_q[grant_idx]);
      count_d[grant_idx] = count_q[grant_idx] - count_t'(1);
      if (count_q[grant_idx] == count_t'(1)) state_d[grant_idx] = e_idle;
      rr_d = grant_idx + idx_t'(1);
    end
    if (alloc_we) begin
      state_d[alloc_idx]  = e_active;
      pc_d[alloc_idx]     = alloc_pc_i;
      addr_d[alloc_idx]   = alloc_addr_i + sext(alloc_stride_i);
      stride_d[alloc_idx] = alloc_stride_i;
      count_d[alloc_idx]  = alloc_count_i;
    end
    for (int i = 0; i < streams_p; i++) begin
      if (kill_hit[i]) state_d[i] = e_idle;
    end
    if (clear_i) begin
      for (int i = 0; i < streams_p; i++) state_d[i] = e_idle;
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < streams_p; i++) begin
        state_q[i]  <= e_idle;
        pc_q[i]     <= '0;
        addr_q[i]   <= '0;
        stride_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

endmodule

// File: tb/tb_bp_be_multistream_prefetch_gen.sv
// Scenario bench for the multi-stream prefetch generator; expected issues are
// queued when descriptors are driven and popped as the DUT issues them.
module tb_bp_be_multistream_prefetch_gen;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        alloc_v_i;
  logic        alloc_ready_and_o;
  logic [38:0] alloc_pc_i;
  logic [38:0] alloc_addr_i;
  logic [7:0]  alloc_stride_i;
  logic [7:0]  alloc_count_i;
  logic        clear_i;
  logic        kill_v_i;
  logic [38:0] kill_pc_i;
  logic        pref_v_o;
  logic [38:0] pref_addr_o;
  logic [38:0] pref_pc_o;
  logic [1:0]  pref_stream_o;
  logic        pref_yumi_i;
  logic [3:0]  active_o;

  typedef struct packed {
    logic [38:0] addr;
    logic [38:0] pc;
    logic [1:0]  slot;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int passed = 0;
  int total = 0;

  bp_be_multistream_prefetch_gen dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .alloc_v_i(alloc_v_i),
    .alloc_ready_and_o(alloc_ready_and_o),
    .alloc_pc_i(alloc_pc_i),
    .alloc_addr_i(alloc_addr_i),
    .alloc_stride_i(alloc_stride_i),
    .alloc_count_i(alloc_count_i),
    .clear_i(clear_i),
    .kill_v_i(kill_v_i),
    .kill_pc_i(kill_pc_i),
    .pref_v_o(pref_v_o),
    .pref_addr_o(pref_addr_o),
    .pref_pc_o(pref_pc_o),
    .pref_stream_o(pref_stream_o),
    .pref_yumi_i(pref_yumi_i),
    .active_o(active_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset_i = 1'b1;
    alloc_v_i = 1'b0;
    alloc_pc_i = '0;
    alloc_addr_i = '0;
    alloc_stride_i = '0;
    alloc_count_i = '0;
    clear_i = 1'b0;
    kill_v_i = 1'b0;
    kill_pc_i = '0;
    pref_yumi_i = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic do_alloc(input logic [38:0] pc, input logic [38:0] addr,
                          input logic [7:0] st, input logic [7:0] cnt);
    @(negedge clk);
    alloc_v_i = 1'b1;
    alloc_pc_i = pc;
    alloc_addr_i = addr;
    alloc_stride_i = st;
    alloc_count_i = cnt;
    @(posedge clk);
    #1 alloc_v_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (pref_v_o !== 1'b0) $display("FAIL reset_pref_v got=%b exp=0", pref_v_o);
    else passed++;
    total++;
    if (active_o !== 4'h0) $display("FAIL reset_active got=%h exp=0", active_o);
    else passed++;
    total++;
    if (alloc_ready_and_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", alloc_ready_and_o);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    do_alloc(39'h100, 39'h1000, 8'd8, 8'd3);
    for (int j = 1; j <= 3; j++) q.push_back({39'h1000 + 39'(8 * j), 39'h100, 2'd0});
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      @(negedge clk);
      if (pref_v_o) begin
        e = q.pop_front();
        total++;
        if ({pref_addr_o, pref_pc_o, pref_stream_o} !== e)
          $display("FAIL single_issue got addr=%h pc=%h slot=%0d exp addr=%h pc=%h slot=%0d",
                   pref_addr_o, pref_pc_o, pref_stream_o, e.addr, e.pc, e.slot);
        else passed++;
        pref_yumi_i = 1'b1;
      end else pref_yumi_i = 1'b0;
    end
    @(negedge clk);
    pref_yumi_i = 1'b0;
    total++;
    if (q.size() != 0) $display("FAIL single_timeout left=%0d exp=0", q.size());
    else passed++;
    total++;
    if ({pref_v_o, active_o} !== 5'b0) $display("FAIL single_done got v=%b act=%h exp 0", pref_v_o, active_o);
    else passed++;
  endtask

  task automatic test_fairness();
    longint st[4] = '{8, 16, -8, 64};
    logic [38:0] base[4] = '{39'h2000, 39'h3000, 39'h4000, 39'h5000};
    do_reset();
    for (int k = 0; k < 4; k++) do_alloc(39'h200 + 39'(4 * k), base[k], 8'(st[k]), 8'd3);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        q.push_back({base[k] + 39'(st[k] * longint'(r + 1)), 39'h200 + 39'(4 * k), 2'(k)});
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      @(negedge clk);
      if (pref_v_o) begin
        e = q.pop_front();
        total++;
        if ({pref_addr_o, pref_pc_o, pref_stream_o} !== e)
          $display("FAIL fair_issue got addr=%h pc=%h slot=%0d exp addr=%h pc=%h slot=%0d",
                   pref_addr_o, pref_pc_o, pref_stream_o, e.addr, e.pc, e.slot);
        else passed++;
        pref_yumi_i = 1'b1;
      end else pref_yumi_i = 1'b0;
    end
    @(negedge clk);
    pref_yumi_i = 1'b0;
    total++;
    if (q.size() != 0 || active_o !== 4'h0)
      $display("FAIL fair_done got left=%0d act=%h exp 0/0", q.size(), active_o);
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) do_alloc(39'h300 + 39'(4 * k), 39'h10000 * 39'(k + 1), 8'd8, 8'd2);
    @(negedge clk);
    total++;
    if (active_o !== 4'hf) $display("FAIL full_active got=%h exp=f", active_o);
    else passed++;
    alloc_v_i = 1'b1;
    alloc_pc_i = 39'h400;
    alloc_addr_i = 39'h8000;
    alloc_stride_i = 8'd8;
    alloc_count_i = 8'd3;
    #1;
    total++;
    if (alloc_ready_and_o !== 1'b0) $display("FAIL full_ready_miss got=%b exp=0", alloc_ready_and_o);
    else passed++;
    @(posedge clk);
    #1 alloc_pc_i = 39'h308;
    alloc_addr_i = 39'h9000;
    #1;
    total++;
    if (alloc_ready_and_o !== 1'b1) $display("FAIL full_ready_hit got=%b exp=1", alloc_ready_and_o);
    else passed++;
    @(posedge clk);
    #1 alloc_v_i = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        if (k == 2) q.push_back({39'h9000 + 39'(8 * (r + 1)), 39'h308, 2'd2});
        else q.push_back({39'h10000 * 39'(k + 1) + 39'(8 * (r + 1)), 39'h300 + 39'(4 * k), 2'(k)});
    q.push_back({39'h9018, 39'h308, 2'd2});
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      @(negedge clk);
      if (pref_v_o) begin
        e = q.pop_front();
        total++;
        if ({pref_addr_o, pref_pc_o, pref_stream_o} !== e)
          $display("FAIL full_issue got addr=%h pc=%h slot=%0d exp addr=%h pc=%h slot=%0d",
                   pref_addr_o, pref_pc_o, pref_stream_o, e.addr, e.pc, e.slot);
        else passed++;
        pref_yumi_i = 1'b1;
      end else pref_yumi_i = 1'b0;
    end
    @(negedge clk);
    pref_yumi_i = 1'b0;
    total++;
    if (q.size() != 0 || active_o !== 4'h0)
      $display("FAIL full_done got left=%0d act=%h exp 0/0", q.size(), active_o);
    else passed++;
  endtask

  task automatic test_kill_clear();
    do_reset();
    for (int k = 0; k < 3; k++) do_alloc(39'h500 + 39'(4 * k), 39'h5000 + 39'h1000 * 39'(k), 8'd4, 8'd5);
    @(negedge clk);
    total++;
    if ({pref_addr_o, pref_stream_o} !== {39'h5004, 2'd0})
      $display("FAIL kill_first got addr=%h slot=%0d exp addr=5004 slot=0", pref_addr_o, pref_stream_o);
    else passed++;
    pref_yumi_i = 1'b1;
    @(negedge clk);
    pref_yumi_i = 1'b0;
    kill_v_i = 1'b1;
    kill_pc_i = 39'h999;
    total++;
    if (pref_stream_o !== 2'd1) $display("FAIL kill_grant1 got=%0d exp=1", pref_stream_o);
    else passed++;
    @(negedge clk);
    kill_pc_i = 39'h504;
    total++;
    if (active_o !== 4'b0111) $display("FAIL kill_nomatch got=%h exp=7", active_o);
    else passed++;
    @(negedge clk);
    kill_v_i = 1'b0;
    total++;
    if ({active_o, pref_stream_o} !== {4'b0101, 2'd2})
      $display("FAIL kill_granted got act=%h slot=%0d exp act=5 slot=2", active_o, pref_stream_o);
    else passed++;
    kill_v_i = 1'b1;
    kill_pc_i = 39'h500;
    alloc_v_i = 1'b1;
    alloc_pc_i = 39'h500;
    alloc_addr_i = 39'h1234;
    alloc_stride_i = 8'd8;
    alloc_count_i = 8'd3;
    @(negedge clk);
    kill_v_i = 1'b0;
    alloc_v_i = 1'b0;
    total++;
    if (active_o !== 4'b0100) $display("FAIL kill_alloc_same got=%h exp=4", active_o);
    else passed++;
    clear_i = 1'b1;
    alloc_v_i = 1'b1;
    alloc_pc_i = 39'h600;
    @(negedge clk);
    clear_i = 1'b0;
    alloc_v_i = 1'b0;
    total++;
    if ({pref_v_o, active_o} !== 5'b0) $display("FAIL clear_alloc got v=%b act=%h exp 0", pref_v_o, active_o);
    else passed++;
  endtask

  task automatic test_edges();
    do_reset();
    do_alloc(39'h700, 39'h7F_FFFF_FFF8, 8'd8, 8'd2);
    do_alloc(39'h704, 39'h4000, 8'd8, 8'd0);
    do_alloc(39'h70c, 39'h4000, 8'd0, 8'd4);
    @(negedge clk);
    total++;
    if (active_o !== 4'b0001) $display("FAIL edge_zero got=%h exp=1", active_o);
    else passed++;
    do_alloc(39'h708, 39'h1000, 8'h80, 8'd2);
    q.push_back({39'h0, 39'h700, 2'd0});
    q.push_back({39'hF80, 39'h708, 2'd1});
    q.push_back({39'h8, 39'h700, 2'd0});
    q.push_back({39'hF00, 39'h708, 2'd1});
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      @(negedge clk);
      if (pref_v_o) begin
        e = q.pop_front();
        total++;
        if ({pref_addr_o, pref_pc_o, pref_stream_o} !== e)
          $display("FAIL edge_issue got addr=%h pc=%h slot=%0d exp addr=%h pc=%h slot=%0d",
                   pref_addr_o, pref_pc_o, pref_stream_o, e.addr, e.pc, e.slot);
        else passed++;
        pref_yumi_i = 1'b1;
      end else pref_yumi_i = 1'b0;
    end
    @(negedge clk);
    pref_yumi_i = 1'b0;
    total++;
    if (q.size() != 0 || active_o !== 4'h0)
      $display("FAIL edge_done got left=%0d act=%h exp 0/0", q.size(), active_o);
    else passed++;
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    do_alloc(39'h800, 39'h2000, 8'd16, 8'd4);
    do_alloc(39'h804, 39'h3000, 8'd16, 8'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({pref_v_o, pref_addr_o, pref_pc_o, pref_stream_o} !== {1'b1, 39'h2010, 39'h800, 2'd0})
        $display("FAIL bp_stable got v=%b addr=%h pc=%h slot=%0d exp 1/2010/800/0",
                 pref_v_o, pref_addr_o, pref_pc_o, pref_stream_o);
      else passed++;
    end
    pref_yumi_i = 1'b1;
    @(negedge clk);
    pref_yumi_i = 1'b0;
    total++;
    if ({pref_addr_o, pref_stream_o} !== {39'h3010, 2'd1})
      $display("FAIL bp_next got addr=%h slot=%0d exp 3010/1", pref_addr_o, pref_stream_o);
    else passed++;
    #2 reset_i = 1'b1;
    #1;
    total++;
    if ({pref_v_o, active_o} !== 5'b0) $display("FAIL async_reset got v=%b act=%h exp 0", pref_v_o, active_o);
    else passed++;
    @(negedge clk);
    reset_i = 1'b0;
    do_alloc(39'h900, 39'h6000, 8'd8, 8'd2);
    do_alloc(39'h904, 39'h7000, 8'd8, 8'd2);
    @(negedge clk);
    total++;
    if ({pref_addr_o, pref_stream_o} !== {39'h6008, 2'd0})
      $display("FAIL rr_after_reset got addr=%h slot=%0d exp 6008/0", pref_addr_o, pref_stream_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_kill_clear();
    test_edges();
    test_backpressure_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
